// File: rtl/zx_mem_pkg.sv
// Shared definitions for the main-RAM slot scheduler: owner codes, slot numbers
// and the scheduler FSM state type.
package zx_mem_pkg;

   localparam logic [1:0] OWNER_IDLE = 2'd0;
   localparam logic [1:0] OWNER_VID  = 2'd1;
   localparam logic [1:0] OWNER_CPU  = 2'd2;
   localparam logic [1:0] OWNER_DMA  = 2'd3;

   localparam logic [1:0] SLOT_VID_ATTR = 2'd0;
   localparam logic [1:0] SLOT_VID_BMP  = 2'd1;

   typedef enum logic [2:0] {
      IDLE,
      VID,
      CPU,
      DMA_SETUP,
      DMA_STROBE
   } slotState_t;

   function automatic logic [1:0] ownerOf(slotState_t s);
      logic [1:0] o;
      o = OWNER_IDLE;
      case (s)
         VID:        o = OWNER_VID;
         CPU:        o = OWNER_CPU;
         DMA_SETUP:  o = OWNER_DMA;
         DMA_STROBE: o = OWNER_DMA;
         default:    o = OWNER_IDLE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/dma_starve_counter.sv
// Counts slot starts a DMA request has waited; flags starvation once the
// count reaches the limit so the next CPU slot is handed to DMA.
module dma_starve_counter #(
   parameter int STARVE_LIMIT = 6
) (
   input  logic CLK_14MHZ,
   input  logic CPU_RESET,
   input  logic inc_i,
   input  logic clear_i,
   output logic starved_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = 4'd0;
      else if (inc_i && (count_q < LIMIT))
         count_d = count_q + 4'd1;
   end

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET)
         count_q <= 4'd0;
      else
         count_q <= count_d;
   end

   assign starved_o = (count_q >= LIMIT);

endmodule

// File: rtl/ram_slot_scheduler.sv
// Fixed four-slot arbiter for the single-ported main RAM, locked to hc0[3:0].
// Every output is registered: each edge computes what the next tick should show.
module ram_slot_scheduler #(
   parameter int AW           = 19,
   parameter int STARVE_LIMIT = 6
) (
   input  logic          CLK_14MHZ,
   input  logic          CPU_RESET,
   input  logic [3:0]    phase,
   input  logic          video_active,
   input  logic          cpu_mreq_n,
   input  logic          cpu_rd_n,
   input  logic          cpu_wr_n,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_wdata,
   output logic          dma_ack,
   output logic [7:0]    dma_rdata,
   input  logic [7:0]    md_in,
   output logic [1:0]    sel,
   output logic          vid_attr_stb,
   output logic          vid_bmp_stb,
   output logic          ram_cs_n,
   output logic          ram_we_n,
   output logic          dma_md_oe,
   output logic          cpu_wait_n
);

   import zx_mem_pkg::*;

   slotState_t state_q, state_d;

   logic [3:0] nextPhase;
   logic       slotStart;
   logic       dmaReqLive;
   logic       vidSlot;
   logic       freeSlot;
   logic       starved;
   logic       starveInc;
   logic       dmaSlot;

   logic       vidGroup_q, vidGroup_d;
   logic       dmaWe_q, dmaWe_d;
   logic [1:0] sel_q, sel_d;
   logic       attrStb_q, attrStb_d;
   logic       bmpStb_q, bmpStb_d;
   logic       csN_q, csN_d;
   logic       weN_q, weN_d;
   logic       mdOe_q, mdOe_d;
   logic       ack_q, ack_d;
   logic [7:0] rdata_q, rdata_d;
   logic       waitN_q, waitN_d;

   // Address, write data and the CPU strobes are steered by the top-level MA/MD mux.
   logic unusedInputs;
   assign unusedInputs = ^{dma_addr, dma_wdata, cpu_rd_n, cpu_wr_n};

   // The request seen during the ack tick is the one just served, so it must not win again.
   always_comb begin
      nextPhase  = phase + 4'd1;
      slotStart  = (nextPhase[1:0] == 2'd0);
      dmaReqLive = dma_req && !ack_q;
      freeSlot   = !nextPhase[3];

      vidSlot = 1'b0;
      if (nextPhase[3:2] == SLOT_VID_ATTR)
         vidSlot = video_active;
      else if (nextPhase[3:2] == SLOT_VID_BMP)
         vidSlot = vidGroup_q;

      vidGroup_d = (phase == 4'hF) ? video_active : vidGroup_q;

      state_d = state_q;
      dmaWe_d = dmaWe_q;
      if (slotStart) begin
         if (vidSlot)
            state_d = VID;
         else if (dmaReqLive && starved)
            state_d = DMA_SETUP;
         else if (!cpu_mreq_n)
            state_d = CPU;
         else if (dmaReqLive && freeSlot)
            state_d = DMA_SETUP;
         else
            state_d = IDLE;
         if (state_d == DMA_SETUP)
            dmaWe_d = dma_we;
      end else if (state_q == DMA_SETUP) begin
         state_d = DMA_STROBE;
      end

      dmaSlot   = (state_d == DMA_SETUP) || (state_d == DMA_STROBE);
      starveInc = slotStart && dmaReqLive && !dmaSlot;

      sel_d     = ownerOf(state_d);
      csN_d     = !((state_d == VID) || dmaSlot);
      weN_d     = !((state_d == DMA_STROBE) && dmaWe_d && (nextPhase[1:0] != 2'd3));
      mdOe_d    = dmaSlot && dmaWe_d;
      attrStb_d = (state_d == VID) && (nextPhase == 4'd3);
      bmpStb_d  = (state_d == VID) && (nextPhase == 4'd7);
      ack_d     = (state_d == DMA_STROBE) && (nextPhase[1:0] == 2'd3);
      waitN_d   = !(!cpu_mreq_n && (sel_d != OWNER_CPU));

      rdata_d = rdata_q;
      if (ack_d && !dmaWe_d)
         rdata_d = md_in;
   end

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         state_q    <= IDLE;
         vidGroup_q <= 1'b0;
         dmaWe_q    <= 1'b0;
         sel_q      <= OWNER_IDLE;
         attrStb_q  <= 1'b0;
         bmpStb_q   <= 1'b0;
         csN_q      <= 1'b1;
         weN_q      <= 1'b1;
         mdOe_q     <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= 8'h00;
         waitN_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         vidGroup_q <= vidGroup_d;
         dmaWe_q    <= dmaWe_d;
         sel_q      <= sel_d;
         attrStb_q  <= attrStb_d;
         bmpStb_q   <= bmpStb_d;
         csN_q      <= csN_d;
         weN_q      <= weN_d;
         mdOe_q     <= mdOe_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         waitN_q    <= waitN_d;
      end
   end

   dma_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) starveCounter (
      .CLK_14MHZ (CLK_14MHZ),
      .CPU_RESET (CPU_RESET),
      .inc_i     (starveInc),
      .clear_i   (ack_q),
      .starved_o (starved)
   );

   assign sel          = sel_q;
   assign vid_attr_stb = attrStb_q;
   assign vid_bmp_stb  = bmpStb_q;
   assign ram_cs_n     = csN_q;
   assign ram_we_n     = weN_q;
   assign dma_md_oe    = mdOe_q;
   assign dma_ack      = ack_q;
   assign dma_rdata    = rdata_q;
   assign cpu_wait_n   = waitN_q;

endmodule

// File: tb/tb_ram_slot_scheduler.sv
// Bench for ram_slot_scheduler: directed scenarios then random traffic, all
// checked against a slot-level model of the arbitration rules.
module tb_ram_slot_scheduler;

   localparam int AW    = 19;
   localparam int LIMIT = 6;

   logic          CLK_14MHZ = 1'b0;
   logic          CPU_RESET = 1'b1;
   logic [3:0]    phase = 4'd0;
   logic          video_active = 1'b0;
   logic          cpu_mreq_n = 1'b1;
   logic          cpu_rd_n = 1'b1;
   logic          cpu_wr_n = 1'b1;
   logic          dma_req = 1'b0;
   logic          dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [7:0]    dma_wdata = 8'h00;
   logic          dma_ack;
   logic [7:0]    dma_rdata;
   logic [7:0]    md_in;
   logic [1:0]    sel;
   logic          vid_attr_stb, vid_bmp_stb, ram_cs_n, ram_we_n, dma_md_oe, cpu_wait_n;

   int testCount = 0;
   int failCount = 0;

   // Physical RAM seen by the DUT (low address byte only) and the model's copy.
   logic [7:0] ram [0:255];
   logic [7:0] expMem [0:255];
   logic       ramClear = 1'b1;

   // Model state: owner of the current slot and the outputs expected this tick.
   logic [1:0] mOwner;
   logic       mWe, mVidGrp;
   logic [7:0] mAddr, mWdata;
   int         mStarve;
   logic [1:0] eSel;
   logic       eAck, eCsN, eWeN, eOe, eAttr, eBmp, eWaitN;
   logic [7:0] eRdata;

   ram_slot_scheduler #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
      .CLK_14MHZ    (CLK_14MHZ),
      .CPU_RESET    (CPU_RESET),
      .phase        (phase),
      .video_active (video_active),
      .cpu_mreq_n   (cpu_mreq_n),
      .cpu_rd_n     (cpu_rd_n),
      .cpu_wr_n     (cpu_wr_n),
      .dma_req      (dma_req),
      .dma_we       (dma_we),
      .dma_addr     (dma_addr),
      .dma_wdata    (dma_wdata),
      .dma_ack      (dma_ack),
      .dma_rdata    (dma_rdata),
      .md_in        (md_in),
      .sel          (sel),
      .vid_attr_stb (vid_attr_stb),
      .vid_bmp_stb  (vid_bmp_stb),
      .ram_cs_n     (ram_cs_n),
      .ram_we_n     (ram_we_n),
      .dma_md_oe    (dma_md_oe),
      .cpu_wait_n   (cpu_wait_n)
   );

   initial forever #35 CLK_14MHZ = ~CLK_14MHZ;

   assign md_in = (sel == 2'd3 && !dma_md_oe) ? ram[dma_addr[7:0]] : 8'hEE;

   always @(posedge CLK_14MHZ) begin
      if (ramClear) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      end else if (!ram_we_n && sel == 2'd3 && dma_md_oe) begin
         ram[dma_addr[7:0]] <= dma_wdata;
      end
   end

   task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (phase %0h)", tag, obs, exp, phase);
      end
   endtask

   task automatic checkOutput();
      checkValue("sel",          8'(sel),          8'(eSel));
      checkValue("vid_attr_stb", 8'(vid_attr_stb), 8'(eAttr));
      checkValue("vid_bmp_stb",  8'(vid_bmp_stb),  8'(eBmp));
      checkValue("ram_cs_n",     8'(ram_cs_n),     8'(eCsN));
      checkValue("ram_we_n",     8'(ram_we_n),     8'(eWeN));
      checkValue("dma_md_oe",    8'(dma_md_oe),    8'(eOe));
      checkValue("dma_ack",      8'(dma_ack),      8'(eAck));
      checkValue("dma_rdata",    dma_rdata,        eRdata);
      checkValue("cpu_wait_n",   8'(cpu_wait_n),   8'(eWaitN));
   endtask

   task automatic modelReset();
      mOwner = 2'd0; mWe = 1'b0; mVidGrp = 1'b0; mAddr = 8'h00; mWdata = 8'h00; mStarve = 0;
      eSel = 2'd0; eAck = 1'b0; eCsN = 1'b1; eWeN = 1'b1; eOe = 1'b0;
      eAttr = 1'b0; eBmp = 1'b0; eWaitN = 1'b1; eRdata = 8'h00;
   endtask

   // Slot-level rules: pick the owner at each slot start by priority, then derive
   // each tick's expected outputs from the owner and the position inside the slot.
   task automatic modelAdvance();
      logic [3:0] np;
      logic       reqLive, vidSlot, ackNow;
      np = phase + 4'd1;
      reqLive = dma_req && !eAck;
      if (np[1:0] == 2'd0) begin
         vidSlot = (np[3:2] == 2'd0) ? video_active : ((np[3:2] == 2'd1) ? mVidGrp : 1'b0);
         if (vidSlot)                         mOwner = 2'd1;
         else if (reqLive && mStarve >= LIMIT) mOwner = 2'd3;
         else if (!cpu_mreq_n)                mOwner = 2'd2;
         else if (reqLive && np < 4'd8)       mOwner = 2'd3;
         else                                 mOwner = 2'd0;
         if (mOwner == 2'd3) begin
            mWe = dma_we; mAddr = dma_addr[7:0]; mWdata = dma_wdata;
         end
         if (eAck) mStarve = 0;
         else if (reqLive && mOwner != 2'd3 && mStarve < LIMIT) mStarve++;
      end
      if (phase == 4'hF) mVidGrp = video_active;
      ackNow = (mOwner == 2'd3) && (np[1:0] == 2'd3);
      if (ackNow) begin
         if (mWe) expMem[mAddr] = mWdata;
         else     eRdata = expMem[mAddr];
      end
      eAck   = ackNow;
      eSel   = mOwner;
      eCsN   = !(mOwner == 2'd1 || mOwner == 2'd3);
      eWeN   = !(mOwner == 2'd3 && mWe && (np[1:0] == 2'd1 || np[1:0] == 2'd2));
      eOe    = (mOwner == 2'd3) && mWe;
      eAttr  = (mOwner == 2'd1) && (np == 4'd3);
      eBmp   = (mOwner == 2'd1) && (np == 4'd7);
      eWaitN = !(!cpu_mreq_n && mOwner != 2'd2);
   endtask

   task automatic tick();
      if (CPU_RESET) modelAdvance();
      @(posedge CLK_14MHZ);
      #1;
      phase = phase + 4'd1;
      checkOutput();
   endtask

   task automatic runToPhase(input logic [3:0] p);
      for (int i = 0; i < 16 && phase != p; i++) tick();
   endtask

   task automatic applyStimulus(input logic va, input logic mreqN, input logic req,
                                input logic we, input logic [AW-1:0] addr, input logic [7:0] wd);
      video_active = va; cpu_mreq_n = mreqN; dma_req = req;
      dma_we = we; dma_addr = addr; dma_wdata = wd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) expMem[i] = 8'h00;
      modelReset();
      #5 CPU_RESET = 1'b0;
      #5 checkOutput();
      repeat (3) tick();
      CPU_RESET = 1'b1;
      ramClear = 1'b0;

      // Video fetch only.
      video_active = 1'b1;
      runToPhase(4'hF);
      tick();
      checkValue("t1_sel_slot0", 8'(sel), 8'd1);
      repeat (3) tick();
      checkValue("t1_attr_ph3", 8'(vid_attr_stb), 8'd1);
      repeat (4) tick();
      checkValue("t1_bmp_ph7", 8'(vid_bmp_stb), 8'd1);
      tick();
      checkValue("t1_sel_slot2", 8'(sel), 8'd0);

      // CPU contends with video.
      runToPhase(4'h1);
      cpu_mreq_n = 1'b0;
      tick();
      checkValue("t2_wait_ph2", 8'(cpu_wait_n), 8'd0);
      runToPhase(4'h8);
      checkValue("t2_wait_ph8", 8'(cpu_wait_n), 8'd1);
      checkValue("t2_sel_ph8", 8'(sel), 8'd2);
      repeat (2) tick();
      cpu_mreq_n = 1'b1;

      // DMA write then read back.
      runToPhase(4'hE);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 19'h7C000, 8'hA5);
      repeat (2) tick();
      checkValue("t3_sel_dma", 8'(sel), 8'd3);
      checkValue("t3_cs_n", 8'(ram_cs_n), 8'd0);
      checkValue("t3_md_oe", 8'(dma_md_oe), 8'd1);
      tick();
      checkValue("t3_we_ph1", 8'(ram_we_n), 8'd0);
      tick();
      checkValue("t3_we_ph2", 8'(ram_we_n), 8'd0);
      tick();
      checkValue("t3_ack_ph3", 8'(dma_ack), 8'd1);
      dma_req = 1'b0;
      runToPhase(4'hE);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 19'h7C000, 8'h00);
      repeat (5) tick();
      checkValue("t3_rd_ack", 8'(dma_ack), 8'd1);
      checkValue("t3_rd_data", dma_rdata, 8'hA5);
      dma_req = 1'b0;

      // Starvation under continuous CPU traffic.
      runToPhase(4'hE);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 19'h7C000, 8'h00);
      for (int i = 0; i < (LIMIT + 1) * 16 && dma_ack !== 1'b1; i++) tick();
      checkValue("t4_ack", 8'(dma_ack), 8'd1);
      checkValue("t4_ack_phase", 8'(phase), 8'h0B);
      checkValue("t4_wait", 8'(cpu_wait_n), 8'd0);
      checkValue("t4_rdata", dma_rdata, 8'hA5);
      dma_req = 1'b0;
      cpu_mreq_n = 1'b1;

      // Reset in the middle of a DMA slot.
      runToPhase(4'hE);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 19'h00012, 8'h3C);
      repeat (3) tick();
      checkValue("t5_sel_before", 8'(sel), 8'd3);
      CPU_RESET = 1'b0;
      modelReset();
      #1 checkOutput();
      checkValue("t5_sel_rst", 8'(sel), 8'd0);
      repeat (3) tick();
      CPU_RESET = 1'b1;
      for (int i = 0; i < 40 && dma_ack !== 1'b1; i++) tick();
      checkValue("t5_ack_after", 8'(dma_ack), 8'd1);
      checkValue("t5_ack_phase", 8'(phase), 8'h03);

      // Random traffic obeying the DMA handshake.
      for (int i = 0; i < 600; i++) begin
         if (dma_ack) begin
            dma_req = 1'b0;
         end else if (!dma_req && $urandom_range(0, 3) == 0) begin
            dma_req   = 1'b1;
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = {11'h000, 8'($urandom_range(0, 15))};
            dma_wdata = 8'($urandom);
         end
         cpu_mreq_n = ($urandom_range(0, 2) != 0);
         if (phase == 4'hE) video_active = 1'($urandom_range(0, 1));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
